// File: rtl/tb_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_pkg : configuration, response-queue entry type and range check
// Revision   : 1.0
// ----------------------------------------------------------------------------
package tb_mem_pkg;

  localparam int IDX_W   = 4;
  localparam int PCN_W   = 28;
  localparam int MCN_W   = 28;
  localparam int DATA_W  = 512;
  localparam int DEPTH   = 8;
  localparam int LAT     = 4;
  localparam int MEM_AW  = 10;
  localparam int TIMER_W = $clog2(LAT) + 1;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic               rnw;
    logic               err;
    logic [DATA_W-1:0]  data;
    logic [TIMER_W-1:0] timer;
  } mem_ent_t;

  function automatic logic in_range(input logic [PCN_W-1:0] pcn);
    return (pcn >> MEM_AW) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tb_mem_rsp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_rsp_if : request/response channel between MMU memory port and model
// Revision      : 1.0
// ----------------------------------------------------------------------------
interface tb_mem_rsp_if #(
  parameter int IDX_W  = tb_mem_pkg::IDX_W,
  parameter int PCN_W  = tb_mem_pkg::PCN_W,
  parameter int MCN_W  = tb_mem_pkg::MCN_W,
  parameter int DATA_W = tb_mem_pkg::DATA_W
);

  logic              req_ready;
  logic              req_valid;
  logic [IDX_W-1:0]  req_idx;
  logic              req_rnw;
  logic [MCN_W-1:0]  req_mcn;
  logic [PCN_W-1:0]  req_pcn;
  logic [DATA_W-1:0] req_data;

  logic              resp_ready;
  logic              resp_valid;
  logic [IDX_W-1:0]  resp_idx;
  logic              resp_err;
  logic              resp_rnw;
  logic [DATA_W-1:0] resp_data;

  modport master (
    input  req_ready, resp_valid, resp_idx, resp_err, resp_rnw, resp_data,
    output req_valid, req_idx, req_rnw, req_mcn, req_pcn, req_data, resp_ready
  );

  modport slave (
    output req_ready, resp_valid, resp_idx, resp_err, resp_rnw, resp_data,
    input  req_valid, req_idx, req_rnw, req_mcn, req_pcn, req_data, resp_ready
  );

endinterface
`default_nettype wire

// File: rtl/tb_mem_rsp_q.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_rsp_q : in-order response FIFO, each entry with its own latency timer
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_mem_rsp_q #(
  parameter int DEPTH = tb_mem_pkg::DEPTH
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  input  wire logic                 push,
  input  tb_mem_pkg::mem_ent_t      push_ent,
  input  wire logic                 pop,
  output tb_mem_pkg::mem_ent_t      head,
  output logic                      head_ready,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    occ
);

  import tb_mem_pkg::*;

  localparam int AW = $clog2(DEPTH);

  mem_ent_t       ents [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Timers of free slots also count down; they are overwritten on the next push.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr[AW-1:0] == AW'(i))) begin
        ents[i] <= push_ent;
      end else if (ents[i].timer != '0) begin
        ents[i].timer <= ents[i].timer - 1'b1;
      end
    end
  end

  assign occ        = wr_ptr - rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = ents[rd_ptr[AW-1:0]];
  assign head_ready = (occ != '0) && (head.timer == '0);

endmodule
`default_nettype wire

// File: rtl/tb_mem_rsp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_rsp : memory responder with backing store, bounded outstanding
//              requests, minimum latency and out-of-range error flagging
// Revision   : 1.0
// ----------------------------------------------------------------------------
module tb_mem_rsp #(
  parameter int IDX_W  = tb_mem_pkg::IDX_W,
  parameter int PCN_W  = tb_mem_pkg::PCN_W,
  parameter int MCN_W  = tb_mem_pkg::MCN_W,
  parameter int DATA_W = tb_mem_pkg::DATA_W,
  parameter int DEPTH  = tb_mem_pkg::DEPTH,
  parameter int LAT    = tb_mem_pkg::LAT,
  parameter int MEM_AW = tb_mem_pkg::MEM_AW
) (
  input  wire logic               clock,
  input  wire logic               reset,
  tb_mem_rsp_if.slave             bus,
  output logic [$clog2(DEPTH):0]  occ
);

  import tb_mem_pkg::*;

  // The queue entry layout comes from the package, so overrides must agree with it.
  if (IDX_W != tb_mem_pkg::IDX_W || PCN_W != tb_mem_pkg::PCN_W ||
      MCN_W != tb_mem_pkg::MCN_W || DATA_W != tb_mem_pkg::DATA_W ||
      LAT != tb_mem_pkg::LAT || MEM_AW != tb_mem_pkg::MEM_AW) begin : g_cfg_mismatch
    $error("tb_mem_rsp parameters disagree with tb_mem_pkg");
  end

  logic [DATA_W-1:0] store [2**MEM_AW];

  logic     full;
  logic     accept;
  logic     pop;
  logic     req_err;
  logic     head_ready;
  logic     unused_mcn;
  mem_ent_t push_ent;
  mem_ent_t head;

  assign unused_mcn    = ^bus.req_mcn;
  assign req_err       = !in_range(bus.req_pcn);
  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;

  // Reads snapshot the pre-edge store so later writes cannot alter queued data.
  always_comb begin
    push_ent       = '0;
    push_ent.idx   = bus.req_idx;
    push_ent.rnw   = bus.req_rnw;
    push_ent.err   = req_err;
    push_ent.timer = TIMER_W'(LAT - 1);
    if (bus.req_rnw && !req_err) begin
      push_ent.data = store[bus.req_pcn[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && accept && !bus.req_rnw && !req_err) begin
      store[bus.req_pcn[MEM_AW-1:0]] <= bus.req_data;
    end
  end

  tb_mem_rsp_q #(
    .DEPTH (DEPTH)
  ) u_q (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_ent   (push_ent),
    .pop        (pop),
    .head       (head),
    .head_ready (head_ready),
    .full       (full),
    .occ        (occ)
  );

  assign pop            = head_ready && bus.resp_ready;
  assign bus.resp_valid = head_ready;
  assign bus.resp_idx   = head_ready ? head.idx  : '0;
  assign bus.resp_err   = head_ready ? head.err  : 1'b0;
  assign bus.resp_rnw   = head_ready ? head.rnw  : 1'b0;
  assign bus.resp_data  = head_ready ? head.data : '0;

  function automatic logic [DATA_W-1:0] peek(input logic [PCN_W-1:0] pcn);
    return store[pcn[MEM_AW-1:0]];
  endfunction

endmodule
`default_nettype wire

// File: tb/tb_tb_mem_rsp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tb_mem_rsp : directed self-checking bench for tb_mem_rsp
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_tb_mem_rsp;

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};
  localparam logic [511:0] PAT_D0 = {16{32'h0BAD_F00D}};
  localparam logic [511:0] PAT_11 = 512'h11;
  localparam logic [511:0] PAT_22 = 512'h22;

  logic       clk;
  logic       rst;
  logic [3:0] occ;
  int         n_checks;
  int         n_fail;

  tb_mem_rsp_if bus ();

  tb_mem_rsp dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .occ   (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic slot;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] idx, input logic rnw, input logic [27:0] pcn,
                       input logic [511:0] data);
    bus.req_valid = 1'b1;
    bus.req_idx   = idx;
    bus.req_rnw   = rnw;
    bus.req_mcn   = 28'(idx) + 28'h100;
    bus.req_pcn   = pcn;
    bus.req_data  = data;
  endtask

  // One request, waits for its acceptance and then for its response.
  task automatic xact(input logic [3:0] idx, input logic rnw, input logic [27:0] pcn,
                      input logic [511:0] data, output logic [3:0] g_idx, output logic g_err,
                      output logic g_rnw, output logic [511:0] g_data, output bit ok);
    bit acc;
    acc = 1'b0;
    ok  = 1'b0;
    bus.resp_ready = 1'b1;
    drive(idx, rnw, pcn, data);
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.req_ready;
      slot();
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 20 && acc && !ok; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        g_idx  = bus.resp_idx;
        g_err  = bus.resp_err;
        g_rnw  = bus.resp_rnw;
        g_data = bus.resp_data;
        ok     = 1'b1;
      end
      slot();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    n_checks++; if ({bus.resp_idx, bus.resp_err, bus.resp_rnw} !== 6'd0 || bus.resp_data !== '0) begin
      n_fail++; $display("FAIL reset_resp_fields: got idx=%h err=%b rnw=%b expected all zero", bus.resp_idx, bus.resp_err, bus.resp_rnw);
    end
    slot();
  endtask

  task automatic test_write_read;
    bit exp_v;
    bus.resp_ready = 1'b1;
    drive(4'd1, 1'b0, 28'h5, PAT_A5);
    for (int k = 0; k <= 6; k++) begin
      if (k == 1) drive(4'd2, 1'b1, 28'h5, '0);
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
      exp_v = (k == 4 || k == 5);
      n_checks++; if (bus.resp_valid !== exp_v) begin n_fail++; $display("FAIL wr_rd_valid_cycle%0d: got %b expected %b", k, bus.resp_valid, exp_v); end
      if (k == 4) begin
        n_checks++; if (bus.resp_idx !== 4'd1 || bus.resp_rnw !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_data !== '0) begin
          n_fail++; $display("FAIL wr_resp: got idx=%h rnw=%b err=%b expected idx=1 rnw=0 err=0 data=0", bus.resp_idx, bus.resp_rnw, bus.resp_err);
        end
      end
      if (k == 5) begin
        n_checks++; if (bus.resp_idx !== 4'd2 || bus.resp_rnw !== 1'b1 || bus.resp_err !== 1'b0) begin
          n_fail++; $display("FAIL rd_resp_hdr: got idx=%h rnw=%b err=%b expected idx=2 rnw=1 err=0", bus.resp_idx, bus.resp_rnw, bus.resp_err);
        end
        n_checks++; if (bus.resp_data !== PAT_A5) begin n_fail++; $display("FAIL rd_resp_data: got %h expected %h", bus.resp_data, PAT_A5); end
      end
      slot();
    end
  endtask

  task automatic test_oor_write;
    logic [3:0]   g_idx;
    logic         g_err, g_rnw;
    logic [511:0] g_data;
    logic [511:0] pk;
    bit           ok;
    xact(4'd3, 1'b0, 28'h0, PAT_D0, g_idx, g_err, g_rnw, g_data, ok);
    n_checks++; if (ok !== 1'b1 || g_err !== 1'b0) begin n_fail++; $display("FAIL inrange_wr: got ok=%b err=%b expected ok=1 err=0", ok, g_err); end
    xact(4'd4, 1'b0, 28'h400, '1, g_idx, g_err, g_rnw, g_data, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL oor_timeout: got ok=%b expected 1", ok); end
    n_checks++; if (g_err !== 1'b1 || g_idx !== 4'd4 || g_rnw !== 1'b0) begin
      n_fail++; $display("FAIL oor_hdr: got err=%b idx=%h rnw=%b expected err=1 idx=4 rnw=0", g_err, g_idx, g_rnw);
    end
    n_checks++; if (g_data !== '0) begin n_fail++; $display("FAIL oor_data: got %h expected 0", g_data); end
    pk = dut.peek(28'h0);
    n_checks++; if (pk !== PAT_D0) begin n_fail++; $display("FAIL oor_peek0: got %h expected %h", pk, PAT_D0); end
  endtask

  task automatic test_backpressure;
    int acc;
    acc = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 1'b1, 28'h5, '0);
      @(negedge clk);
      if (i >= 8) begin
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready%0d: got %b expected 0", i, bus.req_ready); end
        n_checks++; if (occ !== 4'd8) begin n_fail++; $display("FAIL bp_full_occ%0d: got %0d expected 8", i, occ); end
      end
      if (bus.req_ready) acc++;
      slot();
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 8", acc); end
    repeat (5) slot();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_idx !== 4'(k) || bus.resp_data !== PAT_A5) begin
          n_fail++; $display("FAIL bp_drain%0d: got valid=%b idx=%h expected valid=1 idx=%h", k, bus.resp_valid, bus.resp_idx, 4'(k));
        end
      end else begin
        n_checks++; if (bus.resp_valid !== 1'b0 || occ !== 4'd0) begin
          n_fail++; $display("FAIL bp_empty: got valid=%b occ=%0d expected valid=0 occ=0", bus.resp_valid, occ);
        end
      end
      if (k == 0) begin
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_pop_cycle: got %b expected 0", bus.req_ready); end
      end
      if (k == 1) begin
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", bus.req_ready); end
      end
      slot();
    end
  endtask

  task automatic test_snapshot;
    logic [3:0]   g_idx;
    logic         g_err, g_rnw;
    logic [511:0] g_data;
    bit           ok;
    int           got;
    xact(4'd5, 1'b0, 28'h3, PAT_11, g_idx, g_err, g_rnw, g_data, ok);
    got = 0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) drive(4'd6, 1'b1, 28'h3, '0);
      if (k == 1) drive(4'd7, 1'b0, 28'h3, PAT_22);
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
      if (bus.resp_valid) begin
        if (got == 0) begin
          n_checks++; if (bus.resp_idx !== 4'd6 || bus.resp_data !== PAT_11) begin
            n_fail++; $display("FAIL snap_read: got idx=%h data=%h expected idx=6 data=%h", bus.resp_idx, bus.resp_data, PAT_11);
          end
        end else if (got == 1) begin
          n_checks++; if (bus.resp_idx !== 4'd7 || bus.resp_rnw !== 1'b0 || bus.resp_data !== '0) begin
            n_fail++; $display("FAIL snap_write: got idx=%h rnw=%b expected idx=7 rnw=0 data=0", bus.resp_idx, bus.resp_rnw);
          end
        end
        got++;
      end
      slot();
    end
    n_checks++; if (got !== 2) begin n_fail++; $display("FAIL snap_count: got %0d expected 2", got); end
    xact(4'd8, 1'b1, 28'h3, '0, g_idx, g_err, g_rnw, g_data, ok);
    n_checks++; if (ok !== 1'b1 || g_data !== PAT_22) begin n_fail++; $display("FAIL snap_reread: got %h expected %h", g_data, PAT_22); end
  endtask

  task automatic test_hold;
    logic [3:0]   q_idx [$];
    bit           q_rnw [$];
    bit           q_err [$];
    logic [3:0]   h_idx;
    logic         h_err, h_rnw;
    logic [511:0] h_data, e_data;
    logic [27:0]  pcn;
    bit           held, rnw, err;
    int           sent, rcvd;
    sent = 0;
    rcvd = 0;
    held = 1'b0;
    for (int cyc = 0; cyc < 4000 && rcvd < 200; cyc++) begin
      bus.resp_ready = ($urandom_range(0, 9) < 3);
      if (sent < 200 && $urandom_range(0, 9) < 7) begin
        rnw = (sent % 3) != 0;
        err = (sent % 7) == 0;
        pcn = rnw ? (err ? 28'h400 + 28'(sent) : 28'h5) : (err ? 28'h5000 : 28'h7);
        drive(4'(sent), rnw, pcn, {16{32'(sent)}});
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      if (held) begin
        n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_idx !== h_idx || bus.resp_err !== h_err ||
                        bus.resp_rnw !== h_rnw || bus.resp_data !== h_data) begin
          n_fail++; $display("FAIL hold_stable: got valid=%b idx=%h err=%b rnw=%b expected valid=1 idx=%h err=%b rnw=%b",
                             bus.resp_valid, bus.resp_idx, bus.resp_err, bus.resp_rnw, h_idx, h_err, h_rnw);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        q_idx.push_back(bus.req_idx);
        q_rnw.push_back(bus.req_rnw);
        q_err.push_back(bus.req_pcn >= 28'h400);
        sent++;
      end
      held = 1'b0;
      if (bus.resp_valid) begin
        n_checks++;
        if (q_idx.size() == 0) begin
          n_fail++; $display("FAIL hold_unexpected: got idx=%h expected no response", bus.resp_idx);
        end else begin
          e_data = (q_rnw[0] && !q_err[0]) ? PAT_A5 : '0;
          if (bus.resp_idx !== q_idx[0] || bus.resp_rnw !== q_rnw[0] || bus.resp_err !== q_err[0] || bus.resp_data !== e_data) begin
            n_fail++; $display("FAIL hold_order: got idx=%h rnw=%b err=%b expected idx=%h rnw=%b err=%b",
                               bus.resp_idx, bus.resp_rnw, bus.resp_err, q_idx[0], q_rnw[0], q_err[0]);
          end
          if (bus.resp_ready) begin
            void'(q_idx.pop_front());
            void'(q_rnw.pop_front());
            void'(q_err.pop_front());
            rcvd++;
          end
        end
        if (!bus.resp_ready) begin
          held   = 1'b1;
          h_idx  = bus.resp_idx;
          h_err  = bus.resp_err;
          h_rnw  = bus.resp_rnw;
          h_data = bus.resp_data;
        end
      end
      slot();
    end
    bus.req_valid = 1'b0;
    n_checks++; if (rcvd !== 200) begin n_fail++; $display("FAIL hold_count: got %0d expected 200", rcvd); end
  endtask

  task automatic test_reset_mid;
    logic [3:0]   g_idx;
    logic         g_err, g_rnw;
    logic [511:0] g_data;
    bit           ok;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'(8 + i), 1'b1, 28'h5, '0);
      slot();
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (occ !== 4'd4) begin n_fail++; $display("FAIL mid_occ_before: got %0d expected 4", occ); end
    slot();
    rst = 1'b1;
    slot();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0 || occ !== 4'd0) begin
      n_fail++; $display("FAIL mid_flush: got valid=%b occ=%0d expected valid=0 occ=0", bus.resp_valid, occ);
    end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus.req_ready); end
    bus.resp_ready = 1'b1;
    repeat (6) slot();
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b expected 0", bus.resp_valid); end
    slot();
    xact(4'd12, 1'b1, 28'h5, '0, g_idx, g_err, g_rnw, g_data, ok);
    n_checks++; if (ok !== 1'b1 || g_idx !== 4'd12 || g_data !== PAT_A5) begin
      n_fail++; $display("FAIL mid_store5: got idx=%h data=%h expected idx=c data=%h", g_idx, g_data, PAT_A5);
    end
    xact(4'd13, 1'b1, 28'h3, '0, g_idx, g_err, g_rnw, g_data, ok);
    n_checks++; if (ok !== 1'b1 || g_data !== PAT_22) begin n_fail++; $display("FAIL mid_store3: got %h expected %h", g_data, PAT_22); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_idx    = '0;
    bus.req_rnw    = 1'b0;
    bus.req_mcn    = '0;
    bus.req_pcn    = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_oor_write();
    test_backpressure();
    test_snapshot();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
